// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the 16-bit SPI link (responder and master side).
//   SPI_WORD_W       : frame length in bits
//   SPI_SYNC_STAGES  : default metastability depth on the SPI input pins
//   SPI_CNT_W        : width of the per-frame bit counter
//   SPI_CNT_SAT      : value at which the bit counter stops incrementing
//   spi_slv_state_t  : responder FSM states
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_WORD_W      = 16;
  localparam int SPI_SYNC_STAGES = 2;
  localparam int SPI_CNT_W       = 5;

  // One past a full word: lets an over-long frame be told apart from a
  // good one without the counter ever wrapping back to 16.
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_SAT  = 5'd17;
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_FULL = 5'd16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// N-flop synchroniser for one asynchronous pin, followed by one more flop
// used for edge detection.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   d_i     in  asynchronous pin
//   level_o out synchronised level
//   rise_o  out one-clk pulse on a 0->1 change of level_o
//   fall_o  out one-clk pulse on a 1->0 change of level_o
// Parameters:
//   N       synchroniser depth (>= 2)
//   RST_VAL value every flop takes in reset
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign level_o = sync_q[N-1];
  assign rise_o  = sync_q[N-1] & ~prev_q;
  assign fall_o  = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/spi_slv16.sv
// -----------------------------------------------------------------------------
// spi_slv16
// 16-bit mode-3 SPI responder. SCLK, SS_n and MOSI are oversampled on clk.
// One command word is shifted in per frame while a response word, captured at
// frame start, is shifted out on MISO MSB first.
// Ports:
//   clk         in   system clock (SCLK period >= 8 clk)
//   rst         in   asynchronous active-high reset
//   SCLK        in   serial clock from master, idle high
//   SS_n        in   active-low frame select
//   MOSI        in   serial data from master, MSB first
//   MISO        out  serial data to master, MSB first; 0 while deselected
//   tx_data     in   response word, captured when the frame starts
//   rx_data     out  last complete command word
//   rdy         out  level, set when rx_data is updated by a good frame
//   clr_rdy     in   one-clk pulse clearing rdy (a same-clk set wins)
//   frame_err   out  one-clk pulse on a frame ended with count != 16
//   dbg_state_o out  current FSM state (0 = IDLE, 1 = SHIFT)
//
// Interface contract: there is no valid/ready handshake on the word side.
// rx_data is stable whenever rdy is high; rdy stays high until clr_rdy or the
// start of the next frame. frame_err is a bare pulse, not acknowledged.
// -----------------------------------------------------------------------------
module spi_slv16
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] tx_data,
  output logic [15:0] rx_data,
  output logic        rdy,
  input  logic        clr_rdy,
  output logic        frame_err,
  output logic        dbg_state_o
);

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic sclk_lvl, sclk_rise, sclk_unused_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_unused_rise, mosi_unused_fall;
  logic sclk_lvl_unused, ss_lvl_unused;

  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .d_i     (SCLK),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_unused_fall)
  );

  // SS_n resets to 0 in the synchroniser: if rst is released while a frame
  // is still in progress (pin low), no false SS_fall appears, so the rest of
  // that frame is ignored until the next genuine fall. After a normal reset
  // with the pin high the synchroniser shows a rise, which IDLE ignores.
  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
    .clk     (clk),
    .rst     (rst),
    .d_i     (SS_n),
    .level_o (ss_lvl),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst     (rst),
    .d_i     (MOSI),
    .level_o (mosi_lvl),
    .rise_o  (mosi_unused_rise),
    .fall_o  (mosi_unused_fall)
  );

  assign sclk_lvl_unused = sclk_lvl;
  assign ss_lvl_unused   = ss_lvl;

  // ---------------------------------------------------------------------------
  // Datapath next-state: shift and count on each SCLK rise. These are used
  // by the end-of-frame check too, so a rise landing in the same clk as
  // SS_rise is counted before the length is judged.
  // ---------------------------------------------------------------------------
  spi_slv_state_t        state_q;
  logic [15:0]           shft_q, shft_d;
  logic [SPI_CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]           rx_q;
  logic                  rdy_q;
  logic                  err_q;
  logic                  miso_q;

  always_comb begin
    shft_d = shft_q;
    cnt_d  = cnt_q;
    if (sclk_rise) begin
      shft_d = {shft_q[14:0], mosi_lvl};
      if (cnt_q != SPI_CNT_SAT) begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shft_q  <= 16'h0000;
      cnt_q   <= '0;
      rx_q    <= 16'h0000;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      // Placed first so that a frame completion later in this block wins.
      if (clr_rdy) begin
        rdy_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q <= SHIFT;
            shft_q  <= tx_data;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            // MSB is on the wire well before the master's first sample.
            miso_q  <= tx_data[15];
          end
        end
        SHIFT: begin
          shft_q <= shft_d;
          cnt_q  <= cnt_d;
          miso_q <= shft_d[15];
          if (ss_rise) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            if (cnt_d == SPI_CNT_FULL) begin
              rx_q  <= shft_d;
              rdy_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO        = miso_q;
  assign rx_data     = rx_q;
  assign rdy         = rdy_q;
  assign frame_err   = err_q;
  assign dbg_state_o = state_q;

endmodule
